// File: rtl/oh_skidbuf.sv
// oh_skidbuf: two-entry elastic stage (skid buffer) with valid/ready on both
// sides. Every handshake output comes straight from a flop, so the ready path
// from downstream is cut and no input reaches an output combinationally.
//
// Ports
//   clk        rising-edge clock
//   nreset     synchronous active-low reset
//   flush      synchronous discard of all stored beats
//   in_valid   upstream beat present
//   in_data    upstream payload (DW bits)
//   in_ready   registered; beat accepted on an edge with in_valid & in_ready
//   out_valid  registered; oldest stored beat present
//   out_data   registered payload of the oldest stored beat
//   out_ready  downstream accepts on an edge with out_valid & out_ready
//   count      number of stored beats (0..2)
module oh_skidbuf #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic [1:0]    count
);

    // State is just {skid_valid, main_valid}; SKID_ONLY can never be reached.
    typedef enum logic [1:0] {
        EMPTY     = 2'b00,
        ONE       = 2'b01,
        SKID_ONLY = 2'b10,
        FULL      = 2'b11
    } state_t;

    logic          main_valid, main_valid_nxt;
    logic          skid_valid, skid_valid_nxt;
    logic [DW-1:0] main_data, main_data_nxt;
    logic [DW-1:0] skid_data, skid_data_nxt;
    logic          acc, take;
    state_t        state;

    assign state     = state_t'({skid_valid, main_valid});
    assign acc       = in_valid & in_ready;
    assign take      = main_valid & out_ready;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign count     = {1'b0, main_valid} + {1'b0, skid_valid};

    always_comb begin
        main_valid_nxt = main_valid;
        skid_valid_nxt = skid_valid;
        main_data_nxt  = main_data;
        skid_data_nxt  = skid_data;
        case (state)
            EMPTY: begin
                if (acc) begin
                    main_valid_nxt = 1'b1;
                    main_data_nxt  = in_data;
                end
            end
            ONE: begin
                if (acc && take) begin
                    main_data_nxt = in_data;
                end else if (acc) begin
                    // Downstream stalled: park the new beat in the skid.
                    skid_valid_nxt = 1'b1;
                    skid_data_nxt  = in_data;
                end else if (take) begin
                    main_valid_nxt = 1'b0;
                end
            end
            FULL: begin
                // in_ready is low here, so only a take can move things.
                if (take) begin
                    skid_valid_nxt = 1'b0;
                    main_data_nxt  = skid_data;
                end
            end
            default: begin
                // SKID_ONLY: unreachable, hold everything.
            end
        endcase
        // Flush drops the beats but leaves the payload registers untouched.
        if (flush) begin
            main_valid_nxt = 1'b0;
            skid_valid_nxt = 1'b0;
            main_data_nxt  = main_data;
            skid_data_nxt  = skid_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
            in_ready   <= 1'b0;
        end else begin
            main_valid <= main_valid_nxt;
            skid_valid <= skid_valid_nxt;
            main_data  <= main_data_nxt;
            skid_data  <= skid_data_nxt;
            // Ready for the next cycle means the skid will be free.
            in_ready   <= !skid_valid_nxt;
        end
    end

endmodule

// File: tb/tb_oh_skidbuf.sv
module tb_oh_skidbuf;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic [1:0]    count;

    oh_skidbuf #(.DW(DW)) dut (
        .clk(clk), .nreset(nreset), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .count(count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [DW-1:0] exp_q[$];   // beats the model says are stored, oldest first
    logic [DW-1:0] got_q[$];   // DUT out_data captured on every take
    int  m_cnt = 0;
    bit  m_rdy = 1'b0;
    bit  m_live = 1'b0;
    bit  m_zero = 1'b0;        // out_data must still read as reset value
    bit  m_acc, m_take;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
        end
    endtask

    // Monitor: checks outputs against the model at negedge, then advances the
    // model with the inputs that will be sampled on the coming rising edge.
    always @(negedge clk) begin
        if (m_live) begin
            chk("no_x", {63'd0, $isunknown({out_valid, in_ready, count, out_data})}, 64'd0);
            chk("out_valid", {63'd0, out_valid}, {63'd0, m_cnt != 0});
            chk("count", {62'd0, count}, m_cnt);
            chk("in_ready", {63'd0, in_ready}, {63'd0, m_rdy});
            if (m_cnt != 0)
                chk("out_data", {32'd0, out_data}, {32'd0, exp_q[0]});
            else if (m_zero)
                chk("rst_data", {32'd0, out_data}, 64'd0);
        end
        if (!nreset) begin
            exp_q.delete();
            m_cnt = 0; m_rdy = 1'b0; m_live = 1'b1; m_zero = 1'b1;
        end else begin
            m_take = (m_cnt != 0) && out_ready;
            m_acc  = in_valid && m_rdy;
            if (flush) begin
                exp_q.delete();
                m_cnt = 0; m_rdy = 1'b1;
            end else begin
                if (m_take) begin
                    got_q.push_back(out_data);
                    void'(exp_q.pop_front());
                end
                if (m_acc) begin
                    exp_q.push_back(in_data);
                    m_zero = 1'b0;
                end
                m_cnt = exp_q.size();
                m_rdy = (m_cnt < 2);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until the DUT accepts it.
    task automatic send(input logic [DW-1:0] d);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && guard < 100) begin
            cyc();
            guard++;
        end
        chk("send_timeout", {63'd0, guard >= 100}, 64'd0);
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic chk_got(input string nm, input logic [DW-1:0] want[$]);
        chk({nm, "_len"}, got_q.size(), want.size());
        for (int k = 0; k < want.size() && k < got_q.size(); k++)
            chk(nm, {32'd0, got_q[k]}, {32'd0, want[k]});
    endtask

    initial begin
        logic [DW-1:0] want[$];
        bit r;
        int i, n;

        // Reset for 3 cycles, then a continuous stream 1..8.
        nreset = 1'b0;
        repeat (3) cyc();
        chk("rst_count", {62'd0, count}, 64'd0);
        chk("rst_ready", {63'd0, in_ready}, 64'd0);
        nreset = 1'b1;
        out_ready = 1'b1;
        cyc();
        chk("rel_ready", {63'd0, in_ready}, 64'd1);
        got_q.delete();
        for (int k = 1; k <= 8; k++) begin
            in_valid = 1'b1;
            in_data  = k;
            cyc();
            chk("stream_cnt", {62'd0, count}, 64'd1);
            chk("stream_lat", {32'd0, out_data}, k);
        end
        in_valid = 1'b0;
        repeat (2) cyc();
        want = '{1, 2, 3, 4, 5, 6, 7, 8};
        chk_got("stream", want);

        // Backpressure fill.
        got_q.delete();
        out_ready = 1'b0;
        send(32'hA);
        send(32'hB);
        in_valid = 1'b1;
        in_data  = 32'hC;
        repeat (3) cyc();
        chk("bp_count", {62'd0, count}, 64'd2);
        chk("bp_ready", {63'd0, in_ready}, 64'd0);
        chk("bp_main", {32'd0, out_data}, 64'hA);
        out_ready = 1'b1;
        send(32'hC);
        repeat (3) cyc();
        want = '{32'hA, 32'hB, 32'hC};
        chk_got("bp", want);

        // Alternating out_ready against a continuous 16-beat input.
        got_q.delete();
        i = 0; n = 0;
        while (i < 16 && n < 200) begin
            out_ready = n[0];
            in_valid  = 1'b1;
            in_data   = 32'h100 + i;
            r = in_ready;
            cyc();
            if (r) i++;
            n++;
        end
        chk("alt_done", i, 16);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) cyc();
        want.delete();
        for (int k = 0; k < 16; k++) want.push_back(32'h100 + k);
        chk_got("alt", want);

        // Flush while FULL with in_valid asserted.
        out_ready = 1'b0;
        send(32'h11);
        send(32'h22);
        in_valid = 1'b1;
        in_data  = 32'h33;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_count", {62'd0, count}, 64'd0);
        chk("fl_valid", {63'd0, out_valid}, 64'd0);
        chk("fl_ready", {63'd0, in_ready}, 64'd1);
        got_q.delete();
        out_ready = 1'b1;
        send(32'h55);
        repeat (3) cyc();
        want = '{32'h55};
        chk_got("fl", want);

        // Reset while FULL and stalled.
        out_ready = 1'b0;
        send(32'h66);
        send(32'h77);
        nreset = 1'b0;
        cyc();
        chk("mr_valid", {63'd0, out_valid}, 64'd0);
        chk("mr_ready", {63'd0, in_ready}, 64'd0);
        chk("mr_count", {62'd0, count}, 64'd0);
        chk("mr_data", {32'd0, out_data}, 64'd0);
        nreset = 1'b1;
        got_q.delete();
        out_ready = 1'b1;
        repeat (4) cyc();
        send(32'h88);
        repeat (3) cyc();
        want = '{32'h88};
        chk_got("mr", want);

        // Random traffic with occasional flush; the monitor scoreboards it.
        for (int k = 0; k < 10000; k++) begin
            in_valid  = $urandom_range(1, 0) == 1;
            in_data   = $urandom;
            out_ready = $urandom_range(1, 0) == 1;
            flush     = $urandom_range(63, 0) == 0;
            cyc();
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) cyc();
        chk("drain_count", {62'd0, count}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/oh_skidbuf.md
# oh_skidbuf

Two-entry elastic pipeline stage with valid/ready handshake on both sides, placed directly upstream of rising-edge sampled register stages (oh_reg1 chains) to break the ready path. All outputs are driven from flops: out_valid, out_data and in_ready have no combinational path from any input. The block preserves ordering, never drops or duplicates a beat except on flush, and sustains one beat per cycle when out_ready stays high.

## Interface
- DW, default 32: data width in bits.
- clk, input, 1: clock; all state updates on the rising edge.
- nreset, input, 1: reset, synchronous, active-low; sampled on the rising clk edge.
- flush, input, 1: synchronous clear of all stored beats.
- in_valid, input, 1: upstream beat present.
- in_data, input, DW: upstream beat payload.
- in_ready, output, 1: registered; block accepts a beat on an edge where in_valid & in_ready.
- out_valid, output, 1: registered; downstream beat present.
- out_data, output, DW: registered payload of the oldest stored beat.
- out_ready, input, 1: downstream accepts on an edge where out_valid & out_ready.
- count, output, 2: number of stored beats, 0 to 2.

## Operation
- Storage: main register (main_data, main_valid) drives out_data and out_valid directly. Skid register (skid_data, skid_valid) holds the overflow beat.
- in_ready is a flop loaded each edge with the next value of !skid_valid.
- count = main_valid + skid_valid.
- States are encoded by the valid flags: EMPTY is count 0, ONE is count 1, FULL is count 2. Define acc = in_valid & in_ready and take = out_valid & out_ready.
- EMPTY:
  - acc: go to ONE, main_data <= in_data.
  - otherwise: stay in EMPTY.
- ONE:
  - acc & take: stay in ONE, main_data <= in_data.
  - acc & !take: go to FULL, skid_data <= in_data, main unchanged.
  - !acc & take: go to EMPTY.
  - neither: hold.
- FULL (in_ready = 0, so acc is impossible):
  - take: go to ONE, main_data <= skid_data.
  - otherwise: hold.
- flush = 1 on an edge: main_valid, skid_valid and count go to 0 and in_ready goes to 1.
  - Any beat accepted or taken on that same edge is discarded and counts as consumed.
  - flush overrides every transition above.
- Data registers load only on the transitions listed. They are never cleared by flush.
- Any other combination is unreachable and must hold state. Verification asserts this.

## Timing
- Reset, applied on each edge while nreset = 0:
  - out_valid = 0, in_ready = 0, count = 0.
  - out_data = 0, and the skid data register = 0.
- The first edge with nreset = 1 sets in_ready = 1.
- Reset mid-operation discards all stored beats with no partial output.
- Latency: a beat accepted at edge N appears on out_valid/out_data after edge N (visible in cycle N+1), provided the block was EMPTY, or was ONE with take at edge N.
- Throughput is 1 beat/cycle with out_ready held high. in_ready never drops in that case.
- Backpressure:
  - out_ready low with a beat stored: the next accepted beat goes to the skid register.
  - in_ready falls after that edge. At most one beat lands in the skid after out_ready falls.
- Stability: while out_valid & !out_ready, out_data and out_valid hold unchanged until take or flush.
- in_ready rises in the cycle after the take edge that drains the skid (edge FULL -> ONE).
- Upstream may hold in_valid high with changing data while in_ready = 0. That data is ignored.

## Test plan
- Reset then stream: hold nreset = 0 for 3 cycles, then stream in_data 1..8 with in_valid = 1 and out_ready = 1.
  - Expect in_ready = 1 from the first edge after release.
  - Expect out_data to be 1..8 on consecutive cycles, each one cycle after acceptance, with count = 1 throughout.
- Backpressure fill: stream 0xA, 0xB, 0xC with out_ready = 0.
  - Expect 0xA in main and 0xB in skid, count = 2, in_ready = 0, and 0xC not accepted.
  - Raise out_ready: expect outputs 0xA, 0xB, 0xC in order with no loss.
- Alternating out_ready 1/0 every cycle against a continuous 16-beat input: expect the output sequence to equal the input sequence exactly, count never above 2, and out_data stable whenever it is stalled.
- Flush with FULL plus simultaneous in_valid: expect count = 0 and out_valid = 0 after the edge, and in_ready = 1. The next beat 0x55 emerges alone.
- Drop nreset while FULL and out_ready = 0: expect out_valid = 0, in_ready = 0 and count = 0 on the following cycle. After release, no stale beat appears.
- Random valid/ready for 10k cycles against a scoreboard: expect no dropped, duplicated or reordered beat, and no X on any output after reset.
